// File: rtl/nastilite_regbank_pkg.sv
// Shared response codes, read FSM states and address-to-word decode for the
// NASTILite register bank and later memory-mapped blocks.
package nastilite_regbank_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic {
      R_IDLE,
      R_RESP
   } r_state_e;

   // Byte address to word index; sub-word address bits are dropped.
   function automatic int unsigned word_idx(input logic [63:0] addr, input int unsigned data_w);
      return 32'(addr >> $clog2(data_w / 8));
   endfunction

endpackage

// File: rtl/nasti_if.sv
// NASTILite AW/W/B/AR/R channel bundle; clock and reset travel separately.
interface nasti_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 64
);
   logic                  aw_valid;
   logic                  aw_ready;
   logic [ADDR_W-1:0]     aw_addr;
   logic                  w_valid;
   logic                  w_ready;
   logic [DATA_W-1:0]     w_data;
   logic [DATA_W/8-1:0]   w_strb;
   logic                  b_valid;
   logic                  b_ready;
   logic [1:0]            b_resp;
   logic                  ar_valid;
   logic                  ar_ready;
   logic [ADDR_W-1:0]     ar_addr;
   logic                  r_valid;
   logic                  r_ready;
   logic [DATA_W-1:0]     r_data;
   logic [1:0]            r_resp;

   modport slave (
      input  aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
      output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
   );

   modport master (
      output aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
      input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
   );
endinterface

// File: rtl/nastilite_strb_merge.sv
// Combinational byte-lane merge: each strobed lane takes new_data, the rest keep old_data.
// Zero latency, no flow control.
module nastilite_strb_merge #(
   parameter int DATA_W = 64
) (
   input  logic [DATA_W-1:0]   old_data,
   input  logic [DATA_W-1:0]   new_data,
   input  logic [DATA_W/8-1:0] strb,
   output logic [DATA_W-1:0]   merged
);

   for (genvar b = 0; b < DATA_W / 8; b++) begin : g_lane
      assign merged[8*b +: 8] = strb[b] ? new_data[8*b +: 8] : old_data[8*b +: 8];
   end

endmodule

// File: rtl/nastilite_regbank.sv
// NASTILite config/status register bank: RW words with per-word write pulse, RO status words.
// Write commits one edge after the later AW/W handshake and stalls while B is pending; reads answer one edge after AR.
module nastilite_regbank
   import nastilite_regbank_pkg::*;
#(
   parameter int C_NASTI_ADDR_WIDTH = 8,
   parameter int C_NASTI_DATA_WIDTH = 64,
   parameter int C_NUM_RW_REGS      = 8,
   parameter int C_NUM_RO_REGS      = 4,
   parameter logic [C_NUM_RW_REGS-1:0][C_NASTI_DATA_WIDTH-1:0] C_RW_RESET = '0
) (
   input  logic                                             s_nastilite_clk,
   input  logic                                             s_nastilite_aresetn,
   nasti_if.slave                                           s_nastilite,
   output logic [C_NUM_RW_REGS-1:0][C_NASTI_DATA_WIDTH-1:0] m_cfg_data,
   output logic [C_NUM_RW_REGS-1:0]                         m_cfg_wr_pulse,
   input  logic [C_NUM_RO_REGS-1:0][C_NASTI_DATA_WIDTH-1:0] s_status_data
);

   localparam int DW   = C_NASTI_DATA_WIDTH;
   localparam int SW   = DW / 8;
   localparam int NRW  = C_NUM_RW_REGS;
   localparam int NMAP = C_NUM_RW_REGS + C_NUM_RO_REGS;

   if (DW != 32 && DW != 64) begin : g_bad_data_width
      $error("nastilite_regbank: C_NASTI_DATA_WIDTH must be 32 or 64");
   end
   if (C_NASTI_ADDR_WIDTH > 64 || C_NASTI_ADDR_WIDTH < $clog2(NMAP * SW)) begin : g_bad_addr_width
      $error("nastilite_regbank: C_NASTI_ADDR_WIDTH cannot cover the register map");
   end
   if (NRW < 1 || C_NUM_RO_REGS < 0) begin : g_bad_reg_count
      $error("nastilite_regbank: need at least one RW word and a non-negative RO count");
   end

   logic                          aw_full, w_full, aw_rdy, w_rdy, b_vld;
   logic                          aw_hs, w_hs, commit, wr_rw, wr_ro;
   logic [C_NASTI_ADDR_WIDTH-1:0] aw_addr_q;
   logic [DW-1:0]                 w_data_q, wr_old, wr_merged;
   logic [SW-1:0]                 w_strb_q;
   logic [1:0]                    b_resp_q, wr_resp;
   int unsigned                   aw_idx, ar_idx;
   logic [NRW-1:0]                wr_sel, pulse_q;
   logic [DW-1:0]                 cfg_q     [NRW];
   logic [DW-1:0]                 old_chain [NRW+1];
   logic [DW-1:0]                 rd_chain  [NMAP+1];

   r_state_e                      r_state, r_state_nxt;
   logic                          rst_done, ar_rdy, r_vld, ar_hs;
   logic [DW-1:0]                 r_data_q;
   logic [1:0]                    r_resp_q;

   assign aw_hs  = s_nastilite.aw_valid & aw_rdy;
   assign w_hs   = s_nastilite.w_valid & w_rdy;
   assign commit = aw_full & w_full & ~b_vld;

   assign aw_idx  = word_idx(64'(aw_addr_q), DW);
   assign wr_rw   = aw_idx < NRW;
   assign wr_ro   = !wr_rw && (aw_idx < NMAP);
   assign wr_resp = wr_rw ? RESP_OKAY : (wr_ro ? RESP_SLVERR : RESP_DECERR);

   // A ready drops on its own handshake and only returns one cycle after the slot empties.
   always_ff @(posedge s_nastilite_clk) begin
      if (!s_nastilite_aresetn) begin
         aw_full   <= 1'b0;
         w_full    <= 1'b0;
         aw_rdy    <= 1'b0;
         w_rdy     <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         b_vld     <= 1'b0;
         b_resp_q  <= RESP_OKAY;
         pulse_q   <= '0;
      end else begin
         aw_rdy  <= ~aw_full & ~aw_hs;
         w_rdy   <= ~w_full & ~w_hs;
         pulse_q <= wr_sel;
         if (aw_hs) begin
            aw_full   <= 1'b1;
            aw_addr_q <= s_nastilite.aw_addr;
         end else if (commit) begin
            aw_full <= 1'b0;
         end
         if (w_hs) begin
            w_full   <= 1'b1;
            w_data_q <= s_nastilite.w_data;
            w_strb_q <= s_nastilite.w_strb;
         end else if (commit) begin
            w_full <= 1'b0;
         end
         if (commit) begin
            b_vld    <= 1'b1;
            b_resp_q <= wr_resp;
         end else if (b_vld && s_nastilite.b_ready) begin
            b_vld <= 1'b0;
         end
      end
   end

   assign old_chain[0] = '0;
   assign wr_old       = old_chain[NRW];

   for (genvar i = 0; i < NRW; i++) begin : g_word
      assign wr_sel[i]       = commit && wr_rw && (aw_idx == i);
      assign old_chain[i+1]  = (aw_idx == i) ? cfg_q[i] : old_chain[i];
      assign rd_chain[i+1]   = (ar_idx == i) ? cfg_q[i] : rd_chain[i];
      assign m_cfg_data[i]   = cfg_q[i];

      always_ff @(posedge s_nastilite_clk) begin
         if (!s_nastilite_aresetn) begin
            cfg_q[i] <= C_RW_RESET[i];
         end else if (wr_sel[i]) begin
            cfg_q[i] <= wr_merged;
         end
      end
   end

   assign m_cfg_wr_pulse = pulse_q;

   nastilite_strb_merge #(
      .DATA_W (DW)
   ) u_strb_merge (
      .old_data (wr_old),
      .new_data (w_data_q),
      .strb     (w_strb_q),
      .merged   (wr_merged)
   );

   assign ar_idx      = word_idx(64'(s_nastilite.ar_addr), DW);
   assign rd_chain[0] = '0;

   for (genvar j = 0; j < C_NUM_RO_REGS; j++) begin : g_status
      assign rd_chain[NRW+j+1] = (ar_idx == NRW + j) ? s_status_data[j] : rd_chain[NRW+j];
   end

   // rst_done keeps ar_ready low through reset and for the first cycle after release.
   always_comb begin
      r_state_nxt = r_state;
      ar_rdy      = 1'b0;
      r_vld       = 1'b0;
      case (r_state)
         R_IDLE: begin
            ar_rdy = rst_done;
            if (s_nastilite.ar_valid && rst_done) r_state_nxt = R_RESP;
         end
         R_RESP: begin
            r_vld = 1'b1;
            if (s_nastilite.r_ready) r_state_nxt = R_IDLE;
         end
         default: r_state_nxt = R_IDLE;
      endcase
   end

   assign ar_hs = s_nastilite.ar_valid & ar_rdy;

   always_ff @(posedge s_nastilite_clk) begin
      if (!s_nastilite_aresetn) begin
         r_state  <= R_IDLE;
         rst_done <= 1'b0;
         r_data_q <= '0;
         r_resp_q <= RESP_OKAY;
      end else begin
         r_state  <= r_state_nxt;
         rst_done <= 1'b1;
         if (ar_hs) begin
            r_data_q <= rd_chain[NMAP];
            r_resp_q <= (ar_idx < NMAP) ? RESP_OKAY : RESP_DECERR;
         end
      end
   end

   assign s_nastilite.aw_ready = aw_rdy;
   assign s_nastilite.w_ready  = w_rdy;
   assign s_nastilite.b_valid  = b_vld;
   assign s_nastilite.b_resp   = b_resp_q;
   assign s_nastilite.ar_ready = ar_rdy;
   assign s_nastilite.r_valid  = r_vld;
   assign s_nastilite.r_data   = r_data_q;
   assign s_nastilite.r_resp   = r_resp_q;

endmodule
